// File: rtl/key_filter_multi.sv
// ============================================================================
// Module   : key_filter_multi
// Brief    : Multi-channel key synchroniser/debouncer with press, release,
//            long-press and auto-repeat event pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_filter_multi #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int CNT_WIDTH       = 26
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_filter0 = 2'd1;
  localparam logic [1:0] c_down    = 2'd2;
  localparam logic [1:0] c_filter1 = 2'd3;

  localparam logic                 c_released = (ACTIVE_LOW != 0);
  localparam logic                 c_rep_en   = (REPEAT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] c_deb_last  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_long_last = CNT_WIDTH'(LONG_CYCLES - 1);
  // With repeat disabled the terminal value is never compared, so park it at 0.
  localparam logic [CNT_WIDTH-1:0] c_rep_last  =
    CNT_WIDTH'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic                 r_sync1;
    logic                 r_sync2;
    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_dcnt;
    logic [CNT_WIDTH-1:0] r_hcnt;
    logic                 r_rep;
    logic                 r_key_state;
    logic                 r_press;
    logic                 r_release;
    logic                 r_long;
    logic                 r_repeat;
    logic                 w_s;

    assign w_s = r_sync2 ^ c_released;

    always_ff @(posedge Clk) begin
      if (!Rst_n) begin
        r_sync1     <= c_released;
        r_sync2     <= c_released;
        r_state     <= c_idle;
        r_dcnt      <= '0;
        r_hcnt      <= '0;
        r_rep       <= 1'b0;
        r_key_state <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
        r_repeat    <= 1'b0;
      end else begin
        r_sync1   <= key_in[i];
        r_sync2   <= r_sync1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
        case (r_state)
          c_idle: begin
            if (w_s) begin
              r_state <= c_filter0;
              r_dcnt  <= '0;
            end
          end
          c_filter0: begin
            if (!w_s) begin
              r_state <= c_idle;
            end else if (r_dcnt == c_deb_last) begin
              r_state     <= c_down;
              r_press     <= 1'b1;
              r_key_state <= 1'b1;
              r_hcnt      <= '0;
              r_rep       <= 1'b0;
            end else begin
              r_dcnt <= r_dcnt + 1'b1;
            end
          end
          c_down: begin
            // hcnt is left untouched on the way out so a release bounce resumes it
            if (!w_s) begin
              r_state <= c_filter1;
              r_dcnt  <= '0;
            end else if (!r_rep) begin
              if (r_hcnt == c_long_last) begin
                r_long <= 1'b1;
                r_rep  <= 1'b1;
                r_hcnt <= '0;
              end else begin
                r_hcnt <= r_hcnt + 1'b1;
              end
            end else if (c_rep_en) begin
              if (r_hcnt == c_rep_last) begin
                r_repeat <= 1'b1;
                r_hcnt   <= '0;
              end else begin
                r_hcnt <= r_hcnt + 1'b1;
              end
            end
          end
          c_filter1: begin
            if (w_s) begin
              r_state <= c_down;
            end else if (r_dcnt == c_deb_last) begin
              r_state     <= c_idle;
              r_release   <= 1'b1;
              r_key_state <= 1'b0;
            end else begin
              r_dcnt <= r_dcnt + 1'b1;
            end
          end
          default: begin
            r_state     <= c_idle;
            r_key_state <= 1'b0;
          end
        endcase
      end
    end

    assign key_state[i]   = r_key_state;
    assign key_press[i]   = r_press;
    assign key_release[i] = r_release;
    assign key_long[i]    = r_long;
    assign key_repeat[i]  = r_repeat;
  end

endmodule

`default_nettype wire

// File: doc/key_filter_multi.md
# key_filter_multi

Parametrised multi-channel key debouncer and event generator. Each of `NUM_KEYS` raw mechanical key inputs is synchronised and debounced. Each channel produces a stable pressed level plus single-cycle press, release, long-press and auto-repeat events. It sits between the board key pins and the UI/control logic, and replaces the single-key filter in new designs.

## Interface
- `NUM_KEYS`, 4: number of independent key channels (≥1).
- `ACTIVE_LOW`, 1: 1 means the raw key reads 0 when pressed; 0 means it reads 1 when pressed.
- `DEBOUNCE_CYCLES`, 1000000: stable cycles required to accept a press or a release (≥2).
- `LONG_CYCLES`, 50000000: cycles held in DOWN before `key_long` fires (≥2).
- `REPEAT_CYCLES`, 10000000: auto-repeat period after a long press. 0 disables repeat.
- `CNT_WIDTH`, 26: counter width. Must represent max(DEBOUNCE, LONG, REPEAT) − 1.
- `Clk`  in  1  system clock; everything is clocked on the rising edge.
- `Rst_n`  in  1  reset, synchronous, active-low.
- `key_in`  in  NUM_KEYS  raw asynchronous key pins.
- `key_state`  out  NUM_KEYS  debounced level; 1 = pressed.
- `key_press`  out  NUM_KEYS  1-cycle pulse when a press is accepted.
- `key_release`  out  NUM_KEYS  1-cycle pulse when a release is accepted.
- `key_long`  out  NUM_KEYS  1-cycle pulse, at most once per press.
- `key_repeat`  out  NUM_KEYS  1-cycle pulse every REPEAT_CYCLES after `key_long`.

## Operation
- **Per-channel front end**
  - 2-flop synchroniser, then polarity normalisation.
  - The normalised level `s` is 1 when pressed.
- **Per-channel FSM states:** IDLE, FILTER0, DOWN, FILTER1.
- **Per-channel counters:**
  - debounce counter `dcnt`.
  - hold counter `hcnt`.
  - repeat-mode flag `rep`.
- **IDLE**
  - On `s=1`: go to FILTER0, `dcnt<=0`.
- **FILTER0**
  - `s=0`: back to IDLE. This is a bounce; no event.
  - `s=1` and `dcnt==DEBOUNCE_CYCLES-1`: go to DOWN. Pulse `key_press`, set `key_state`, `hcnt<=0`, `rep<=0`.
  - Otherwise `dcnt++`.
- **DOWN**
  - On `s=0`: go to FILTER1, `dcnt<=0`, `hcnt` frozen.
  - Otherwise `hcnt++`, with these checks:
    - `!rep` and `hcnt==LONG_CYCLES-1`: pulse `key_long`, `rep<=1`, `hcnt<=0`.
    - `rep`, REPEAT_CYCLES≠0 and `hcnt==REPEAT_CYCLES-1`: pulse `key_repeat`, `hcnt<=0`.
- **FILTER1**
  - `s=1`: back to DOWN. `hcnt` and `rep` resume unchanged; no event.
  - `s=0` and `dcnt==DEBOUNCE_CYCLES-1`: go to IDLE. Pulse `key_release`, clear `key_state`.
  - Otherwise `dcnt++`.
- **Default state:** illegal encodings return to IDLE with all channel outputs 0.
- **Channel independence:** channels share no state. Simultaneous events on different channels give simultaneous pulses.
- **Pulse rules**
  - `key_press` and `key_release` never fire in the same cycle on one channel.
  - `key_long` and `key_repeat` fire only while `key_state=1`.
- **Counter width:** counters never wrap. Each is cleared at its terminal value or on a state change.

## Timing
- **Reset:** `Rst_n=0` sampled at an edge sets the following:
  - all outputs 0;
  - all FSMs to IDLE;
  - counters and `rep` to 0;
  - synchroniser flops to the released level (ACTIVE_LOW ? 1 : 0).
- **Reset mid-press:** no `key_release` is generated. If the key is still held after reset, it produces a fresh `key_press` after the normal latency.
- **Press latency:** with `key_in` stable pressed from edge 0, `key_press` and `key_state` are high after edge DEBOUNCE_CYCLES+3.
  - 2 edges: synchroniser.
  - 1 edge: IDLE→FILTER0.
  - DEBOUNCE_CYCLES edges: FILTER0.
- **Release latency:** the same, DEBOUNCE_CYCLES+3 edges from a stable release.
- **Long press:** `key_long` fires LONG_CYCLES edges after entering DOWN, excluding frozen cycles spent in FILTER1.
- **Repeat:** `key_repeat` fires every REPEAT_CYCLES edges thereafter.
- **Pulse width:** every event pulse is exactly 1 cycle wide and registered, with no combinational path from `key_in`.

## Test plan
Bench parameters: NUM_KEYS=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=8, LONG_CYCLES=20, REPEAT_CYCLES=5, CNT_WIDTH=6.
- **Clean press:** ch0 driven 1→0, held 40 cycles, then 0→1.
  - `key_press[0]` pulses at edge 11 after the press.
  - `key_long[0]` pulses 20 cycles after that.
  - `key_repeat[0]` pulses every 5 cycles after `key_long[0]`.
  - `key_release[0]` pulses 11 edges after the release; `key_state[0]` tracks press/release accordingly.
- **Bounce rejection:** ch0 toggles with 3-cycle low glitches (shorter than 8) for 50 cycles.
  - No press, release, long or repeat pulse; `key_state`=0 throughout.
- **Release bounce:** during a hold, a 4-cycle high glitch on ch0.
  - No `key_release`; `key_state` stays 1.
  - `key_long` is delayed by exactly the glitch cycles plus the synchroniser effect. It still fires exactly once.
- **Repeat disabled:** rebuild with REPEAT_CYCLES=0 and hold 100 cycles.
  - One `key_long`, zero `key_repeat`.
- **Independent channels:** ch0 and ch1 pressed on the same edge, ch1 released 30 cycles earlier than ch0.
  - Press pulses coincide; release pulses are 30 cycles apart; no cross-talk.
- **Reset mid-hold:** assert `Rst_n=0` for 2 cycles while ch0 is in DOWN, with the key still held.
  - All outputs 0 during reset; no `key_release`.
  - `key_press[0]` fires again 11 edges after reset is released.
